// File: rtl/stereo_column_feeder.sv
// stereo_column_feeder
//   Walks the stored left and right grayscale frames in raster order and
//   presents one KERNEL_WIDTH-tall pixel column per camera, tagged with its
//   centre coordinates, to the SAD/depth block. Both frame BRAMs share one
//   read address. The depth block's busy signal provides backpressure, so
//   no column is ever dropped.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous, active-high reset
//   start_in        pulse: begin one frame pass (honoured only when idle)
//   sad_busy_in     depth block busy; a column is not accepted while high
//   bram_addr_out   read address shared by the left and right BRAMs
//   bram_left_in    left BRAM read data (READ_LATENCY cycles after address)
//   bram_right_in   right BRAM read data
//   left_data_out   left column, index k holds row v-1+k
//   right_data_out  right column, same packing
//   hcount_out      x of the column on the data outputs
//   vcount_out      centre row y of the column on the data outputs
//   data_valid_out  one-cycle pulse: column presented and accepted
//   busy_out        high from accepted start_in until frame_done_out
//   frame_done_out  one-cycle pulse after the final column
module stereo_column_feeder #(
  parameter int WIDTH        = 320,
  parameter int HEIGHT       = 240,
  parameter int KERNEL_WIDTH = 3,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         start_in,
  input  logic                         sad_busy_in,
  output logic [ADDR_W-1:0]            bram_addr_out,
  input  logic [7:0]                   bram_left_in,
  input  logic [7:0]                   bram_right_in,
  output logic [KERNEL_WIDTH-1:0][7:0] left_data_out,
  output logic [KERNEL_WIDTH-1:0][7:0] right_data_out,
  output logic [10:0]                  hcount_out,
  output logic [9:0]                   vcount_out,
  output logic                         data_valid_out,
  output logic                         busy_out,
  output logic                         frame_done_out
);

  localparam int K_W = $clog2(KERNEL_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, READY} state_t;

  state_t             state;
  state_t             state_next;

  logic [10:0]        cur_h;
  logic [9:0]         cur_v;
  // Linear index (v-1)*WIDTH+h of the top pixel of the current column.
  // Raster order means the next column's top pixel is always this plus one,
  // including across a row wrap.
  logic [ADDR_W-1:0]  col_base;
  logic [K_W-1:0]     issue_cnt;
  logic               guard;
  logic               accept;
  logic               last_col;
  logic               last_capture;

  // Read tags travel alongside the BRAM pipeline: stage 0 lines up with the
  // registered address, stage READ_LATENCY with the data it returns.
  logic               tag_valid [0:READ_LATENCY];
  logic [K_W-1:0]     tag_k     [0:READ_LATENCY];

  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    data_valid_out = 1'b0;
    last_capture   = tag_valid[READ_LATENCY] &&
                     (tag_k[READ_LATENCY] == K_W'(KERNEL_WIDTH - 1));
    last_col       = (cur_h == 11'(WIDTH - 1)) && (cur_v == 10'(HEIGHT - 2));
    case (state)
      IDLE: begin
        if (start_in) state_next = FETCH;
      end
      FETCH: begin
        if (last_capture) state_next = READY;
      end
      READY: begin
        // The depth block raises busy one cycle after accepting, so the
        // cycle after a pulse is ignored via the guard.
        if (!rst_in && !guard && !sad_busy_in) begin
          accept         = 1'b1;
          data_valid_out = 1'b1;
          state_next     = last_col ? IDLE : FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= IDLE;
      cur_h          <= '0;
      cur_v          <= '0;
      col_base       <= '0;
      issue_cnt      <= '0;
      guard          <= 1'b0;
      bram_addr_out  <= '0;
      left_data_out  <= '0;
      right_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_valid[i] <= 1'b0;
        tag_k[i]     <= '0;
      end
    end else begin
      state          <= state_next;
      guard          <= accept;
      frame_done_out <= 1'b0;

      tag_valid[0] <= 1'b0;
      tag_k[0]     <= '0;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_k[i]     <= tag_k[i-1];
      end

      // The first read of each column is issued on the transition into
      // FETCH so the column is ready KERNEL_WIDTH+READ_LATENCY+1 cycles
      // after the previous pulse.
      case (state)
        IDLE: begin
          if (start_in) begin
            busy_out      <= 1'b1;
            cur_h         <= '0;
            cur_v         <= 10'd1;
            col_base      <= '0;
            bram_addr_out <= '0;
            tag_valid[0]  <= 1'b1;
            tag_k[0]      <= '0;
            issue_cnt     <= K_W'(1);
          end
        end
        FETCH: begin
          if (issue_cnt < K_W'(KERNEL_WIDTH)) begin
            bram_addr_out <= bram_addr_out + ADDR_W'(WIDTH);
            tag_valid[0]  <= 1'b1;
            tag_k[0]      <= issue_cnt;
            issue_cnt     <= issue_cnt + K_W'(1);
          end
        end
        READY: begin
          if (accept) begin
            if (last_col) begin
              busy_out       <= 1'b0;
              frame_done_out <= 1'b1;
            end else begin
              if (cur_h == 11'(WIDTH - 1)) begin
                cur_h <= '0;
                cur_v <= cur_v + 10'd1;
              end else begin
                cur_h <= cur_h + 11'd1;
              end
              col_base      <= col_base + ADDR_W'(1);
              bram_addr_out <= col_base + ADDR_W'(1);
              tag_valid[0]  <= 1'b1;
              tag_k[0]      <= '0;
              issue_cnt     <= K_W'(1);
            end
          end
        end
        default: ;
      endcase

      // Coordinates move with the first row of the new column so they
      // always describe what is on the data outputs.
      if (tag_valid[READ_LATENCY]) begin
        left_data_out[tag_k[READ_LATENCY]]  <= bram_left_in;
        right_data_out[tag_k[READ_LATENCY]] <= bram_right_in;
        if (tag_k[READ_LATENCY] == '0) begin
          hcount_out <= cur_h;
          vcount_out <= cur_v;
        end
      end
    end
  end

endmodule

// File: tb/tb_stereo_column_feeder.sv
// tb_stereo_column_feeder
//   Bench for stereo_column_feeder on a 4x4 frame. BRAM model: left pixel =
//   row*16+col, right = ~left. dut1 uses READ_LATENCY=2, dut2 uses
//   READ_LATENCY=1. Expected columns are queued when a frame is started and
//   popped by a monitor on every data_valid_out pulse.
module tb_stereo_column_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int KW = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, start_in, start2_in, sad_busy_in;
  logic [3:0] addr1, addr2;
  logic [7:0] bl1, br1, bl2, br2;
  logic [KW-1:0][7:0] ld1, rd1, ld2, rd2;
  logic [10:0] hc1, hc2;
  logic [9:0]  vc1, vc2;
  logic dv1, dv2, busy1, busy2, done1, done2;

  stereo_column_feeder #(.WIDTH(W), .HEIGHT(H), .KERNEL_WIDTH(KW), .READ_LATENCY(2)) dut1 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .sad_busy_in(sad_busy_in),
    .bram_addr_out(addr1), .bram_left_in(bl1), .bram_right_in(br1),
    .left_data_out(ld1), .right_data_out(rd1), .hcount_out(hc1), .vcount_out(vc1),
    .data_valid_out(dv1), .busy_out(busy1), .frame_done_out(done1));

  stereo_column_feeder #(.WIDTH(W), .HEIGHT(H), .KERNEL_WIDTH(KW), .READ_LATENCY(1)) dut2 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start2_in), .sad_busy_in(sad_busy_in),
    .bram_addr_out(addr2), .bram_left_in(bl2), .bram_right_in(br2),
    .left_data_out(ld2), .right_data_out(rd2), .hcount_out(hc2), .vcount_out(vc2),
    .data_valid_out(dv2), .busy_out(busy2), .frame_done_out(done2));

  function automatic logic [7:0] pix(input logic [3:0] a);
    return 8'((int'(a) / W) * 16 + (int'(a) % W));
  endfunction

  // BRAM models with READ_LATENCY 2 and 1.
  logic [7:0] lp1 [0:1];
  logic [7:0] lp2;
  always @(posedge clk_in) begin
    lp1[0] <= pix(addr1);
    lp1[1] <= lp1[0];
    lp2    <= pix(addr2);
  end
  assign bl1 = lp1[1];
  assign br1 = ~lp1[1];
  assign bl2 = lp2;
  assign br2 = ~lp2;

  typedef struct {
    logic [10:0]        h;
    logic [9:0]         v;
    logic [KW-1:0][7:0] l;
    logic [KW-1:0][7:0] r;
  } col_t;

  typedef struct {
    int          busy_after;
    bit          start_after;
    logic [10:0] h;
    logic [9:0]  v;
  } vec_t;

  col_t q1[$];
  col_t q2[$];
  vec_t vecs[8];

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int last1      = -100;
  int last2      = -100;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic col_t model(input logic [10:0] h, input logic [9:0] v);
    col_t c;
    c.h = h;
    c.v = v;
    for (int k = 0; k < KW; k++) begin
      c.l[k] = 8'((int'(v) - 1 + k) * 16 + int'(h));
      c.r[k] = ~c.l[k];
    end
    return c;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout, want event", name);
  endtask

  // Scoreboard monitors: compare each pulse with the oldest queued column.
  always @(negedge clk_in) begin
    if (dv1) begin
      col_t e;
      if (q1.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut1 unexpected pulse: got h=%0d v=%0d, want no pulse", hc1, vc1);
      end else begin
        e = q1.pop_front();
        checkOutput("dut1 hcount", 64'(hc1), 64'(e.h));
        checkOutput("dut1 vcount", 64'(vc1), 64'(e.v));
        checkOutput("dut1 left", 64'(ld1), 64'(e.l));
        checkOutput("dut1 right", 64'(rd1), 64'(e.r));
      end
      vectors++;
      if (cyc - last1 < 6) begin
        miscompares++;
        $display("[TB] FAIL dut1 spacing: got %0d, want >= 6", cyc - last1);
      end
      checkOutput("dut1 pulse while sad busy", 64'(sad_busy_in), 64'(0));
      last1 = cyc;
    end
  end

  always @(negedge clk_in) begin
    if (dv2) begin
      col_t e;
      if (q2.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL dut2 unexpected pulse: got h=%0d v=%0d, want no pulse", hc2, vc2);
      end else begin
        e = q2.pop_front();
        checkOutput("dut2 hcount", 64'(hc2), 64'(e.h));
        checkOutput("dut2 vcount", 64'(vc2), 64'(e.v));
        checkOutput("dut2 left", 64'(ld2), 64'(e.l));
        checkOutput("dut2 right", 64'(rd2), 64'(e.r));
      end
      vectors++;
      if (cyc - last2 < 5) begin
        miscompares++;
        $display("[TB] FAIL dut2 spacing: got %0d, want >= 5", cyc - last2);
      end
      last2 = cyc;
    end
  end

  task automatic nextCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic waitPulse(input bit which, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_in);
      if ((which == 1'b0 && dv1) || (which == 1'b1 && dv2)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  // One full frame on dut1 driven from the vector table.
  task automatic applyStimulus();
    bit got;
    int budget;
    foreach (vecs[i]) q1.push_back(model(vecs[i].h, vecs[i].v));
    start_in = 1'b1;
    nextCycle();
    start_in = 1'b0;
    checkOutput("dut1 busy after start", 64'(busy1), 64'(1));
    budget = 40;
    for (int i = 0; i < 8; i++) begin
      waitPulse(1'b0, budget, got);
      budget = 40;
      if (!got) begin
        failNow($sformatf("dut1 pulse %0d", i));
        continue;
      end
      checkOutput("dut1 busy during frame", 64'(busy1), 64'(1));
      if (i == 7) begin
        @(negedge clk_in);
        checkOutput("dut1 frame done", 64'(done1), 64'(1));
        checkOutput("dut1 busy after done", 64'(busy1), 64'(0));
      end
      nextCycle();
      if (vecs[i].start_after) begin
        start_in = 1'b1;
        nextCycle();
        start_in = 1'b0;
      end
      if (vecs[i].busy_after > 0 && i < 7) begin
        col_t held;
        held = model(vecs[i+1].h, vecs[i+1].v);
        sad_busy_in = 1'b1;
        for (int j = 0; j < vecs[i].busy_after; j++) begin
          @(negedge clk_in);
          checkOutput("dut1 valid under backpressure", 64'(dv1), 64'(0));
          if (j >= 10) begin
            checkOutput("dut1 held hcount", 64'(hc1), 64'(held.h));
            checkOutput("dut1 held vcount", 64'(vc1), 64'(held.v));
            checkOutput("dut1 held left", 64'(ld1), 64'(held.l));
            checkOutput("dut1 held right", 64'(rd1), 64'(held.r));
          end
          nextCycle();
        end
        sad_busy_in = 1'b0;
        budget = 2;
      end
    end
  endtask

  initial begin
    bit got;
    vecs[0] = '{busy_after: 20, start_after: 1'b0, h: 11'd0, v: 10'd1};
    vecs[1] = '{busy_after: 0,  start_after: 1'b1, h: 11'd1, v: 10'd1};
    vecs[2] = '{busy_after: 0,  start_after: 1'b0, h: 11'd2, v: 10'd1};
    vecs[3] = '{busy_after: 0,  start_after: 1'b0, h: 11'd3, v: 10'd1};
    vecs[4] = '{busy_after: 0,  start_after: 1'b0, h: 11'd0, v: 10'd2};
    vecs[5] = '{busy_after: 0,  start_after: 1'b0, h: 11'd1, v: 10'd2};
    vecs[6] = '{busy_after: 0,  start_after: 1'b0, h: 11'd2, v: 10'd2};
    vecs[7] = '{busy_after: 0,  start_after: 1'b0, h: 11'd3, v: 10'd2};

    rst_in      = 1'b1;
    start_in    = 1'b0;
    start2_in   = 1'b0;
    sad_busy_in = 1'b0;
    repeat (3) nextCycle();
    checkOutput("reset addr", 64'(addr1), 64'(0));
    checkOutput("reset left", 64'(ld1), 64'(0));
    checkOutput("reset right", 64'(rd1), 64'(0));
    checkOutput("reset hcount", 64'(hc1), 64'(0));
    checkOutput("reset vcount", 64'(vc1), 64'(0));
    checkOutput("reset valid", 64'(dv1), 64'(0));
    checkOutput("reset busy", 64'(busy1), 64'(0));
    checkOutput("reset done", 64'(done1), 64'(0));
    rst_in = 1'b0;
    nextCycle();

    $display("[TB] frame with backpressure and ignored start");
    applyStimulus();
    repeat (5) nextCycle();

    $display("[TB] reset mid-frame");
    q1.push_back(model(11'd0, 10'd1));
    q1.push_back(model(11'd1, 10'd1));
    start_in = 1'b1;
    nextCycle();
    start_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      waitPulse(1'b0, 40, got);
      if (!got) failNow("dut1 pulse before reset");
    end
    nextCycle();
    nextCycle();
    rst_in = 1'b1;
    nextCycle();
    nextCycle();
    rst_in = 1'b0;
    q1.delete();
    checkOutput("busy after mid reset", 64'(busy1), 64'(0));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      checkOutput("valid after mid reset", 64'(dv1), 64'(0));
    end
    nextCycle();
    applyStimulus();
    repeat (5) nextCycle();

    $display("[TB] READ_LATENCY=1 frame");
    for (int v = 1; v <= H - 2; v++)
      for (int h = 0; h < W; h++)
        q2.push_back(model(11'(h), 10'(v)));
    start2_in = 1'b1;
    nextCycle();
    start2_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      waitPulse(1'b1, 40, got);
      if (!got) failNow($sformatf("dut2 pulse %0d", i));
    end
    @(negedge clk_in);
    checkOutput("dut2 frame done", 64'(done2), 64'(1));
    checkOutput("dut2 busy after done", 64'(busy2), 64'(0));
    repeat (5) nextCycle();

    checkOutput("dut1 scoreboard drained", 64'(q1.size()), 64'(0));
    checkOutput("dut2 scoreboard drained", 64'(q2.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
